updown_mod_counter: RTL and testbench
=====================================

# updown_mod_counter

Parametrised up/down modulo counter. Successor to the fixed wrap-only up counter. Adds direction control, a programmable terminal value, synchronous load, a wrap/saturate mode, and separate overflow and underflow event pulses. Used as the general-purpose event/timebase counter in the counter library; an optional enable prescaler is available at compile time.

## Interface
- `WIDTH`, 8, counter and modulus width in bits (≥2)
- `PRESCALE_W`, 4, prescale value width (used only when prescaling is compiled in)

- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `en`  in  1  count enable
- `up`  in  1  direction: 1 = increment, 0 = decrement
- `load`  in  1  synchronous load strobe
- `load_val`  in  WIDTH  value loaded when `load`=1
- `modulus`  in  WIDTH  terminal value; legal count range 0..`modulus`
- `sat`  in  1  1 = saturate at bounds, 0 = wrap
- `prescale`  in  PRESCALE_W  step divider; present always, ignored unless macro defined
- `out`  out  WIDTH  current count (registered)
- `overflow`  out  1  one-cycle pulse: up-step attempted at/above `modulus` (registered)
- `underflow`  out  1  one-cycle pulse: down-step attempted at 0 (registered)

## Operation
- Priority per cycle: `rst` > `load` > step > hold.
- `rst`=1: `out`=0, `overflow`=0, `underflow`=0, prescale count=0.
- `load`=1: `out` = min(`load_val`, `modulus`). Pulses are 0 and the prescale count is cleared. `en` is ignored that cycle.
- Step condition: `en`=1 (or the prescaler tick when compiled in).
- Up-step with `out` < `modulus`: `out`+1, no pulse.
- Up-step with `out` ≥ `modulus`: `overflow`=1. Result is `out`=0 if `sat`=0, or `out`=`modulus` if `sat`=1. This covers `modulus` lowered below the current count.
- Down-step with `out` > 0: `out`−1. If `out` > `modulus` (modulus lowered), the result is `modulus` instead. No pulse.
- Down-step with `out`=0: `underflow`=1. Result is `out`=`modulus` if `sat`=0, or `out`=0 if `sat`=1.
- `modulus`=0: `out` stays 0. Every up-step pulses `overflow` and every down-step pulses `underflow`, in both modes.
- `modulus`=2^WIDTH−1: full-range counter. Arithmetic is WIDTH bits with no carry-out leak.
- No step and no load: `out` holds and both pulses are 0.
- `up`, `sat` and `modulus` are sampled every cycle and may change at any cycle; there is no internal latching.

## Timing
- Single clock domain. All outputs come from flops; there are no combinational input-to-output paths.
- Latency: inputs sampled at edge N appear on `out`/pulses after edge N. One-cycle load-to-output.
- A pulse is high for exactly the cycle in which `out` shows the post-wrap/saturated value. Consecutive bound steps give consecutive high cycles.
- `overflow` and `underflow` are never high together.
- Reset mid-count, or together with `load`/`en`, takes effect at that edge; the next cycle shows all zeros.

## Configuration
- Macro `UPDOWN_MOD_COUNTER_PRESCALE_EN`.
- Defined:
  - An internal PRESCALE_W-bit counter advances on each `en`=1 cycle.
  - A step occurs on the `en` cycle where the internal count equals `prescale`; the internal count then returns to 0.
  - So a step occurs every `prescale`+1 enabled cycles; `prescale`=0 steps on every `en` cycle.
  - `en`=0 holds the prescale count. `rst`/`load` clear it.
- Undefined: no prescale flops; step = `en`. The `prescale` port exists but is unused.

## Test plan
- Wrap up: reset, `modulus`=5, `up`=1, `sat`=0, `en`=1 for 7 cycles -> `out` 1,2,3,4,5,0,1; `overflow` high only in the cycle `out`=0.
- Saturate down: load 2, `up`=0, `sat`=1, `en`=1 for 4 cycles -> `out` 1,0,0,0; `underflow` high on cycles 3 and 4.
- Load priority/clamp: `modulus`=100, `load`=1, `load_val`=200, `en`=1 -> `out`=100, no pulses. Then `load_val`=7 -> `out`=7.
- Modulus shrink: `out`=10, set `modulus`=3.
  - `up`=1, `sat`=0 -> `out`=0, `overflow`=1.
  - Repeat with `sat`=1 -> `out`=3, `overflow`=1.
  - With `up`=0 -> `out`=3, no pulse.
- Prescale (macro defined): `prescale`=2, `en` held high -> `out` increments on every 3rd cycle. A 2-cycle `en` gap delays the next step by 2 cycles. Without the macro, `out` increments every cycle.
- Reset mid-operation: `rst`=1 together with `load`=1 and `en`=1 while `overflow` is pulsing -> next cycle `out`=0, `overflow`=0, `underflow`=0. With the macro, the first step after reset takes `prescale`+1 cycles.

Source files
------------

// File: rtl/updown_mod_counter.sv
// updown_mod_counter: parametrised up/down modulo counter with a programmable
// terminal value, synchronous load, wrap/saturate mode and registered
// overflow/underflow event pulses.
//
// Optional feature: define UPDOWN_MOD_COUNTER_PRESCALE_EN to compile in an
// enable prescaler (one step every prescale+1 enabled cycles).
//
// Ports:
//   clk        clock, all state updates on rising edge
//   rst        synchronous active-high reset
//   en         count enable
//   up         direction: 1 = increment, 0 = decrement
//   load       synchronous load strobe (beats en)
//   load_val   value loaded, clamped to modulus
//   modulus    terminal value; legal count range 0..modulus
//   sat        1 = saturate at bounds, 0 = wrap
//   prescale   step divider (ignored unless the prescaler is compiled in)
//   out        current count (registered)
//   overflow   one-cycle pulse: up-step attempted at/above modulus
//   underflow  one-cycle pulse: down-step attempted at 0
module updown_mod_counter #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic [WIDTH-1:0]      modulus,
  input  logic                  sat,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      out,
  output logic                  overflow,
  output logic                  underflow
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             step;

`ifdef UPDOWN_MOD_COUNTER_PRESCALE_EN
  logic [PRESCALE_W-1:0] psc_q, psc_d;

  // Tick on the enabled cycle where the internal count reaches prescale.
  always_comb begin
    step  = 1'b0;
    psc_d = psc_q;
    if (load) begin
      psc_d = '0;
    end else if (en) begin
      if (psc_q == prescale) begin
        step  = 1'b1;
        psc_d = '0;
      end else begin
        psc_d = psc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      psc_q <= '0;
    end else begin
      psc_q <= psc_d;
    end
  end
`else
  logic unused_prescale;
  assign unused_prescale = ^prescale;
  assign step = en;
`endif

  always_comb begin
    count_d = count_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    if (load) begin
      count_d = (load_val > modulus) ? modulus : load_val;
    end else if (step) begin
      if (up) begin
        if (count_q < modulus) begin
          count_d = count_q + 1'b1;
        end else begin
          // Also covers modulus lowered below the current count.
          ovf_d   = 1'b1;
          count_d = sat ? modulus : '0;
        end
      end else begin
        if (count_q == '0) begin
          unf_d   = 1'b1;
          count_d = sat ? '0 : modulus;
        end else if (count_q > modulus) begin
          // Modulus was lowered: pull back into range without a pulse.
          count_d = modulus;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign out       = count_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Scoreboard bench for updown_mod_counter: directed test-plan sequences then
// random stimulus, checked against an integer reference model.
module tb_updown_mod_counter;

  localparam int unsigned WIDTH      = 8;
  localparam int unsigned PRESCALE_W = 4;
  localparam int          MAXV       = (1 << WIDTH) - 1;
  localparam int          PSC_RANGE  = 1 << PRESCALE_W;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  en = 1'b0;
  logic                  up = 1'b0;
  logic                  load = 1'b0;
  logic [WIDTH-1:0]      load_val = '0;
  logic [WIDTH-1:0]      modulus = '0;
  logic                  sat = 1'b0;
  logic [PRESCALE_W-1:0] prescale = '0;
  logic [WIDTH-1:0]      out;
  logic                  overflow;
  logic                  underflow;

  updown_mod_counter #(
    .WIDTH     (WIDTH),
    .PRESCALE_W(PRESCALE_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .modulus  (modulus),
    .sat      (sat),
    .prescale (prescale),
    .out      (out),
    .overflow (overflow),
    .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int o;
    bit ov;
    bit un;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state: count value and enabled cycles since last step.
  int   m_out = 0;
  int   m_en_cnt = 0;

  // Apply one cycle of inputs and queue the response expected after the edge.
  task automatic cyc(input bit r, input bit e, input bit u, input bit l, input int lv,
                     input int md, input bit s, input int ps);
    exp_t x;
    bit   do_step;
    @(negedge clk);
    rst = r; en = e; up = u; load = l; sat = s;
    load_val = lv[WIDTH-1:0];
    modulus  = md[WIDTH-1:0];
    prescale = ps[PRESCALE_W-1:0];
    x.ov = 0;
    x.un = 0;
    if (r) begin
      m_out = 0;
      m_en_cnt = 0;
    end else if (l) begin
      m_out = (lv > md) ? md : lv;
      m_en_cnt = 0;
    end else begin
`ifdef UPDOWN_MOD_COUNTER_PRESCALE_EN
      do_step = 0;
      if (e) begin
        if (m_en_cnt == ps) begin
          do_step = 1;
          m_en_cnt = 0;
        end else begin
          m_en_cnt = (m_en_cnt + 1) % PSC_RANGE;
        end
      end
`else
      do_step = e;
`endif
      if (do_step && u) begin
        if (m_out < md) m_out = m_out + 1;
        else begin
          x.ov = 1;
          m_out = s ? md : 0;
        end
      end else if (do_step) begin
        if (m_out == 0) begin
          x.un = 1;
          m_out = s ? 0 : md;
        end else m_out = (m_out > md) ? md : m_out - 1;
      end
    end
    x.o = m_out;
    exp_q.push_back(x);
  endtask

  // Monitor: the counter presents a result every cycle once stimulus starts.
  initial begin
    exp_t             x;
    logic [WIDTH-1:0] eo;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        x  = exp_q.pop_front();
        eo = x.o[WIDTH-1:0];
        total++;
        if (out !== eo || overflow !== x.ov || underflow !== x.un) begin
          bad++;
          $display("FAIL cycle_check t=%0t: got out=%0d ovf=%b unf=%b, want out=%0d ovf=%b unf=%b",
                   $time, out, overflow, underflow, eo, x.ov, x.un);
        end
      end
    end
  end

  initial begin
    int md, lv;
    bit s, u;
    // Reset, then wrap up with modulus 5.
    cyc(1, 0, 0, 0, 0, 5, 0, 0);
    repeat (7) cyc(0, 1, 1, 0, 0, 5, 0, 0);
    // Saturating count down from 2.
    cyc(0, 0, 0, 1, 2, 5, 1, 0);
    repeat (4) cyc(0, 1, 0, 0, 0, 5, 1, 0);
    // Load priority and clamp.
    cyc(0, 1, 1, 1, 200, 100, 0, 0);
    cyc(0, 1, 1, 1, 7, 100, 0, 0);
    // Modulus shrink below the current count.
    cyc(0, 0, 0, 1, 10, 100, 0, 0);
    cyc(0, 1, 1, 0, 0, 3, 0, 0);
    cyc(0, 0, 0, 1, 10, 100, 0, 0);
    cyc(0, 1, 1, 0, 0, 3, 1, 0);
    cyc(0, 0, 0, 1, 10, 100, 0, 0);
    cyc(0, 1, 0, 0, 0, 3, 0, 0);
    // Prescale 2 with an enable gap.
    cyc(1, 0, 0, 0, 0, 50, 0, 2);
    repeat (9) cyc(0, 1, 1, 0, 0, 50, 0, 2);
    repeat (2) cyc(0, 0, 1, 0, 0, 50, 0, 2);
    repeat (6) cyc(0, 1, 1, 0, 0, 50, 0, 2);
    // Full range: wrap through 255 both ways.
    cyc(0, 0, 0, 1, 254, MAXV, 0, 0);
    repeat (3) cyc(0, 1, 1, 0, 0, MAXV, 0, 0);
    repeat (3) cyc(0, 1, 0, 0, 0, MAXV, 0, 0);
    // Modulus zero in both modes.
    for (int m = 0; m < 4; m++) cyc(0, 1, m[0], 0, 0, 0, m[1], 0);
    // Reset together with load/en while overflow is pulsing.
    repeat (2) cyc(0, 1, 1, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 1, 9, 20, 0, 1);
    repeat (4) cyc(0, 1, 1, 0, 0, 20, 0, 1);

    // Random phase: modulus changes occasionally so bounds are reached often.
    md = 6;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) begin
        case ($urandom_range(3))
          0: md = 0;
          1: md = MAXV;
          2: md = $urandom_range(MAXV);
          default: md = $urandom_range(12);
        endcase
      end
      lv = (md == MAXV) ? $urandom_range(MAXV) : $urandom_range(md + 4 > MAXV ? MAXV : md + 4);
      s  = $urandom_range(3) == 0;
      u  = $urandom_range(2) != 0;
      cyc($urandom_range(199) == 0, $urandom_range(4) != 0, u, $urandom_range(19) == 0,
          lv, md, s, $urandom_range(3));
    end

    @(posedge clk);
    #3;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expected responses left, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
